// File: rtl/vt_image_streamer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vt_image_streamer : Wishbone-loaded word FIFO serialised into a pixel stream
// Rev 1.0
// ----------------------------------------------------------------------------
module vt_image_streamer #(
    parameter int          DATA_WIDTH       = 8,
    parameter int          FIFO_DEPTH       = 16,
    parameter int          PIXELS_PER_FRAME = 786432,
    parameter logic [31:0] BASE_ADDR        = 32'h3000_0000
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_dat_i,
    input  logic [31:0]           wbs_adr_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic [DATA_WIDTH-1:0] o_image_data,
    output logic                  o_image_valid,
    input  logic                  i_stream_ready,
    output logic                  o_frame_done
);
    localparam int            AW         = $clog2(FIFO_DEPTH);
    localparam int            CW         = 20;
    localparam logic [CW-1:0] LAST_PIXEL = CW'(PIXELS_PER_FRAME - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [31:0]   shreg_q, shreg_d;
    logic [1:0]    idx_q, idx_d;
    logic          loaded_q, loaded_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, sel_err_q, sel_err_d;
    logic          ack_q;
    logic [31:0]   rdata_q, rdata_d;

    logic        hit, req, ctrl_wr, data_wr, start, flush, clr_err;
    logic        fifo_empty, fifo_full, xfer, frame_end, push, pop, sel_ok;
    logic [31:0] status;

    assign hit        = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req        = wbs_stb_i && wbs_cyc_i && hit && !ack_q;
    assign ctrl_wr    = req && wbs_we_i && (wbs_adr_i[3:0] == 4'h0);
    assign data_wr    = req && wbs_we_i && (wbs_adr_i[3:0] == 4'h4);
    assign start      = ctrl_wr && wbs_dat_i[0];
    assign flush      = ctrl_wr && wbs_dat_i[1];
    assign clr_err    = ctrl_wr && wbs_dat_i[2];
    assign sel_ok     = (wbs_sel_i == 4'hF);

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FULL_LEVEL);
    assign xfer       = loaded_q && i_stream_ready;
    assign frame_end  = xfer && (count_q == LAST_PIXEL);

    // Refill on the final byte's transfer so back-to-back words stream gaplessly.
    assign pop  = (state_q == ST_STREAM) && !flush && !fifo_empty &&
                  (!loaded_q || (xfer && (idx_q == 2'd3) && !frame_end));
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign push = data_wr && sel_ok && (!fifo_full || pop);

    assign status = {22'd0, 5'(level_q), sel_err_q, ovf_q, fifo_full, fifo_empty,
                     state_q != ST_IDLE};

    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = rdata_q;
    assign o_image_valid = loaded_q;
    assign o_image_data  = shreg_q[{idx_q, 3'b000} +: DATA_WIDTH];
    assign o_frame_done  = (state_q == ST_DONE);

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        loaded_d  = loaded_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        sel_err_d = sel_err_q;
        rdata_d   = 32'd0;

        if (req && !wbs_we_i) begin
            case (wbs_adr_i[3:0])
                4'h8:    rdata_d = 32'(count_q);
                4'hC:    rdata_d = status;
                default: rdata_d = 32'd0;
            endcase
        end

        if (data_wr && !sel_ok) begin
            sel_err_d = 1'b1;
        end else if (data_wr && !push) begin
            ovf_d = 1'b1;
        end
        if (clr_err) begin
            ovf_d     = 1'b0;
            sel_err_d = 1'b0;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (xfer) begin
                    idx_d   = idx_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (frame_end) begin
                        state_d  = ST_DONE;
                        loaded_d = 1'b0;
                    end else if (idx_q == 2'd3) begin
                        loaded_d = 1'b0;
                    end
                end
                if (pop) begin
                    shreg_d  = mem_q[rd_ptr_q];
                    idx_d    = 2'd0;
                    loaded_d = 1'b1;
                end
            end
            ST_DONE: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            loaded_d = 1'b0;
            idx_d    = 2'd0;
            count_d  = '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            shreg_q   <= 32'd0;
            idx_q     <= 2'd0;
            loaded_q  <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            sel_err_q <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            loaded_q  <= loaded_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            sel_err_q <= sel_err_d;
            ack_q     <= req;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wbs_dat_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vt_image_streamer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vt_image_streamer : directed bench with a queue-based stream/register model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_vt_image_streamer;
    localparam int          PPF   = 6;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] wdat = 32'd0, adr = 32'd0;
    logic        ack;
    logic [31:0] rdat;
    logic [7:0]  pix;
    logic        pvalid, fdone;
    logic        ready = 1'b1;

    int n_pass = 0;
    int n_total = 0;

    // Model: words accepted by the FIFO, bytes of the word being emitted, frame state.
    logic [31:0] mdl_fifo[$];
    logic [7:0]  mdl_cur[$];
    int          mdl_count = 0;
    bit          mdl_stream = 0, mdl_ovf = 0, mdl_sel = 0, done_pending = 0;
    int          done_pulses = 0;

    vt_image_streamer #(
        .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .PIXELS_PER_FRAME(PPF), .BASE_ADDR(BASE)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(rdat), .o_image_data(pix),
        .o_image_valid(pvalid), .i_stream_ready(ready), .o_frame_done(fdone)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] mdl_status();
        int n;
        n = mdl_fifo.size();
        return {22'd0, 5'(n), mdl_sel, mdl_ovf, n == DEPTH, n == 0, mdl_stream};
    endfunction

    task automatic mdl_reset();
        mdl_fifo.delete();
        mdl_cur.delete();
        mdl_count  = 0;
        mdl_stream = 0;
        mdl_ovf    = 0;
        mdl_sel    = 0;
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
        @(posedge clk); #1;
        check("ack_after_req", ack, 1'b1);
        r = rdat;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        bus(1'b1, a, d, s, r);
        if (a[31:4] == BASE[31:4]) begin
            case (a[3:0])
                4'h0: begin
                    if (d[1]) begin
                        mdl_fifo.delete();
                        mdl_cur.delete();
                        mdl_count  = 0;
                        mdl_stream = 0;
                    end else if (d[0]) begin
                        mdl_stream = 1;
                    end
                    if (d[2]) begin
                        mdl_ovf = 0;
                        mdl_sel = 0;
                    end
                end
                4'h4: begin
                    if (s != 4'hF) mdl_sel = 1;
                    else if (mdl_fifo.size() >= DEPTH) mdl_ovf = 1;
                    else mdl_fifo.push_back(d);
                end
                default: ;
            endcase
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        bus(1'b0, a, 32'd0, 4'hF, r);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (!pvalid && n < 50);
        check(nm, pvalid, 1'b1);
    endtask

    task automatic wait_done(input string nm);
        int d0 = done_pulses;
        int n = 0;
        do begin @(negedge clk); n++; end while (done_pulses == d0 && n < 200);
        check(nm, 32'(done_pulses - d0), 32'd1);
    endtask

    // Per-cycle compare against the model.
    initial begin
        logic [31:0] w;
        logic [7:0]  prev_data = 8'd0;
        bit          prev_valid = 0, prev_ready = 0, prev_ack = 0, avail;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid   = 0;
                prev_ack     = 0;
                done_pending = 0;
            end else begin
                check("frame_done", fdone, done_pending);
                done_pending = 0;
                if (fdone) done_pulses++;
                if (prev_ack) check("ack_pulse", ack, 1'b0);
                if (!ack) check("rdata_idle", rdat, 32'd0);
                if (prev_valid && !prev_ready) begin
                    check("hold_valid", pvalid, 1'b1);
                    check("hold_data", pix, prev_data);
                end
                if (pvalid && ready) begin
                    avail = (mdl_cur.size() + mdl_fifo.size()) != 0;
                    check("pixel_avail", avail, 1'b1);
                    if (avail) begin
                        if (mdl_cur.size() == 0) begin
                            w = mdl_fifo.pop_front();
                            for (int j = 0; j < 4; j++) mdl_cur.push_back(w[8*j +: 8]);
                        end
                        check("pixel", pix, mdl_cur.pop_front());
                        mdl_count++;
                        if (mdl_count == PPF) begin
                            mdl_cur.delete();
                            mdl_count    = 0;
                            mdl_stream   = 0;
                            done_pending = 1;
                        end
                    end
                end
                prev_valid = pvalid;
                prev_ready = ready;
                prev_data  = pix;
                prev_ack   = ack;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int d0;

        repeat (3) @(negedge clk);
        check("reset_ack", ack, 1'b0);
        check("reset_valid", pvalid, 1'b0);
        check("reset_done", fdone, 1'b0);
        rst_n = 1'b1;
        rd(BASE + 32'hC, r);
        check("reset_status", r, 32'h002);
        rd(BASE + 32'h0, r);
        check("ctrl_reads_zero", r, 32'd0);

        // Single word, consecutive byte order.
        ready = 1'b1;
        wr(BASE + 32'h4, 32'h4433_2211, 4'hF);
        wr(BASE + 32'h0, 32'd1, 4'hF);
        wait_valid("t1_valid");
        check("t1_b0", pix, 8'h11);
        @(negedge clk); check("t1_b1", pix, 8'h22);
        @(negedge clk); check("t1_b2", pix, 8'h33);
        @(negedge clk); check("t1_b3", pix, 8'h44);
        rd(BASE + 32'h8, r);
        check("t1_count", r, 32'd4);
        rd(BASE + 32'hC, r);
        check("t1_status", r, 32'h003);
        check("t1_status_mdl", r, mdl_status());
        wr(BASE + 32'h0, 32'd2, 4'hF);
        rd(BASE + 32'hC, r);
        check("flush_status", r, 32'h002);

        // Address miss and read-only write.
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h4000_0004; wdat = 32'hDEAD_BEEF; sel = 4'hF;
        repeat (3) begin @(posedge clk); #1; check("miss_no_ack", ack, 1'b0); end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        wr(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
        rd(BASE + 32'hC, r);
        check("ro_write_ignored", r, mdl_status());

        // Overfill while idle: word i carries pixels 4i..4i+3.
        for (int i = 0; i < 17; i++)
            wr(BASE + 32'h4, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 4'hF);
        rd(BASE + 32'hC, r);
        check("ovf_status", r, 32'h20C);
        check("ovf_status_mdl", r, mdl_status());
        wr(BASE + 32'h0, 32'd4, 4'hF);
        wr(BASE + 32'h0, 32'd1, 4'hF);
        wait_done("f1_done");
        repeat (2) @(negedge clk);
        rd(BASE + 32'hC, r);
        check("f1_status", r, 32'h1C0);
        check("f1_status_mdl", r, mdl_status());

        // Backpressure mid-word.
        ready = 1'b0;
        wr(BASE + 32'h0, 32'd1, 4'hF);
        wait_valid("stall_valid");
        check("stall_first", pix, 8'h08);
        @(posedge clk); #1; ready = 1'b1;
        @(posedge clk); @(posedge clk); #1; ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", pix, 8'h0A);
        end
        rd(BASE + 32'h8, r);
        check("stall_count", r, 32'd2);
        ready = 1'b1;
        @(negedge clk); check("resume_same", pix, 8'h0A);
        @(negedge clk); check("resume_next", pix, 8'h0B);
        wait_done("f2_done");
        repeat (2) @(negedge clk);
        rd(BASE + 32'hC, r);
        check("f2_status", r, 32'h180);
        wr(BASE + 32'h0, 32'd2, 4'hF);

        // Two-word frame of six pixels, trailing bytes dropped.
        wr(BASE + 32'h4, 32'h0403_0201, 4'hF);
        wr(BASE + 32'h4, 32'h0807_0605, 4'hF);
        d0 = done_pulses;
        wr(BASE + 32'h0, 32'd1, 4'hF);
        wait_done("f3_done");
        repeat (5) @(negedge clk);
        check("f3_single_pulse", 32'(done_pulses - d0), 32'd1);
        rd(BASE + 32'hC, r);
        check("f3_status", r, 32'h002);
        rd(BASE + 32'h8, r);
        check("f3_count", r, 32'd0);

        // Partial byte select.
        wr(BASE + 32'h4, 32'h1234_5678, 4'h3);
        rd(BASE + 32'hC, r);
        check("sel_err_status", r, 32'h012);
        wr(BASE + 32'h0, 32'd4, 4'hF);
        rd(BASE + 32'hC, r);
        check("sel_err_clr", r, 32'h002);

        // Reset mid-stream aborts without a frame_done.
        wr(BASE + 32'h4, 32'hA3A2_A1A0, 4'hF);
        wr(BASE + 32'h4, 32'hA7A6_A5A4, 4'hF);
        wr(BASE + 32'h0, 32'd1, 4'hF);
        wait_valid("rst_valid");
        @(negedge clk); #2;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        check("rst_valid_low", pvalid, 1'b0);
        check("rst_data_zero", pix, 8'h00);
        d0 = done_pulses;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_done", 32'(done_pulses - d0), 32'd0);
        rd(BASE + 32'hC, r);
        check("rst_status", r, 32'h002);
        rd(BASE + 32'h8, r);
        check("rst_count", r, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
